unidade_controle_jogo: RTL and testbench
========================================

Name: unidade_controle_jogo

Overview:
Moore FSM that sequences the memory-game datapath: counter, ROM, key register and comparator. Detects each new key press, registers it, compares it with the ROM word at the current address, and either advances the address or ends the round with acertou/errou. Sits beside the datapath inside the top-level circuit; all datapath enables come from this block.

Parameters:
TIMEOUT_CICLOS, 5000, cycles allowed in ESPERA before a timeout (used only with TIMEOUT_EN); counter width is clog2(TIMEOUT_CICLOS+1).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
iniciar  in  1  start request, level-sampled
chaves  in  4  raw one-hot key inputs
igual  in  1  comparator: registered keys == ROM word
fimC  in  1  counter at last address
zeraC  out  1  synchronous clear of address counter
contaC  out  1  address counter increment enable
zeraR  out  1  synchronous clear of key register
registraR  out  1  key register load enable
pronto  out  1  round finished
acertou  out  1  round ended with all plays correct
errou  out  1  round ended with a wrong play (or timeout)
db_jogada  out  1  one-cycle key-press pulse (debug)
db_timeout  out  1  round ended by timeout (0 when TIMEOUT_EN is off)
db_estado  out  4  state code (debug)

Behaviour:
- Reset (reset=0, asynchronous): state INICIAL, press-detect register 0, timeout counter 0; all outputs 0, db_estado=0.
- Press detection: ativo = |chaves; register prev <= ativo every cycle in every state; jogada = ativo & ~prev. This gives one pulse per 0->nonzero transition. Held keys and nonzero->nonzero changes give no new pulse. jogada outside ESPERA is discarded.
- State codes, with the output asserted in each state (outputs not listed are 0):
  - INICIAL=0x0: none.
  - PREPARACAO=0x1: zeraC=1, zeraR=1.
  - ESPERA=0x2: none.
  - REGISTRA=0x4: registraR=1.
  - COMPARACAO=0x5: none.
  - PROXIMO=0x6: contaC=1.
  - FIM_ACERTOU=0xA: pronto=1, acertou=1.
  - FIM_ERROU=0xE: pronto=1, errou=1.
  - FIM_TIMEOUT=0xD: pronto=1, errou=1, db_timeout=1.
- Transitions:
  - INICIAL: iniciar -> PREPARACAO; else stay.
  - PREPARACAO -> ESPERA, unconditionally.
  - ESPERA: jogada -> REGISTRA; else stay.
  - REGISTRA -> COMPARACAO, unconditionally.
  - COMPARACAO: !igual -> FIM_ERROU; igual & fimC -> FIM_ACERTOU; igual & !fimC -> PROXIMO.
  - PROXIMO -> ESPERA.
  - Any FIM_*: iniciar -> PREPARACAO (restart without reset); else hold.
- All outputs are purely state-decoded and registered-state based; no combinational path from inputs to outputs except db_jogada.
- Latency: press detected at edge N -> registraR high in cycle N+1 -> igual sampled in cycle N+2.
- iniciar is ignored in every state except INICIAL and FIM_*.
- Undefined state codes -> INICIAL.
- Reset mid-round returns to INICIAL immediately and clears all outputs.

Optional Feature:
TIMEOUT_EN
- Defined:
  - Counter increments each cycle spent in ESPERA and clears on leaving ESPERA.
  - Reaching TIMEOUT_CICLOS-1 without a jogada -> FIM_TIMEOUT.
  - If jogada arrives in the same cycle as the timeout, jogada wins (-> REGISTRA).
- Undefined: no counter logic, FIM_TIMEOUT is unreachable, db_timeout is tied to 0.

Test Plan:
- Reset then idle: reset=0 for 1 cycle, iniciar=0 for 5 cycles -> db_estado=0x0, all control outputs 0.
- Start: iniciar=1 for 1 cycle -> one cycle of zeraC=zeraR=1 (db_estado=0x1), then db_estado=0x2.
- Correct round with a 4-address ROM model: drive the matching chaves at each address, returning to 0000 between presses -> exactly one registraR and one contaC per play (3 contaC total), then FIM_ACERTOU: pronto=1, acertou=1, errou=0.
- Wrong play at address 2: igual=0 in COMPARACAO -> FIM_ERROU (0xE), pronto=1, errou=1; holding chaves=0100 for 3 cycles produces only one db_jogada pulse.
- Restart and mid-round reset:
  - iniciar=1 in FIM_ERROU -> PREPARACAO, outputs acertou/errou drop.
  - reset=0 asserted asynchronously in REGISTRA -> db_estado=0x0 before the next clock edge.
- With TIMEOUT_EN, TIMEOUT_CICLOS=8: stay in ESPERA with chaves=0000 -> FIM_TIMEOUT after 8 cycles, db_timeout=1, errou=1. A press on the 8th cycle -> REGISTRA instead.

Source files
------------

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo
// Moore FSM that sequences the memory-game datapath: counter, ROM, key register and
// comparator. Each new key press is registered and compared with the ROM word at the
// current address. A match advances the address. A mismatch, or a match at the last
// address, ends the round.
//
// Optional macro TIMEOUT_EN: when defined, a round ends in FIM_TIMEOUT after
// TIMEOUT_CICLOS cycles in ESPERA without a press. When undefined, db_timeout is tied to 0.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   iniciar    in   start / restart request (level)
//   chaves     in   raw one-hot key inputs [3:0]
//   igual      in   comparator result: registered keys == ROM word
//   fimC       in   address counter at last address
//   zeraC      out  clear address counter
//   contaC     out  increment address counter
//   zeraR      out  clear key register
//   registraR  out  load key register
//   pronto     out  round finished
//   acertou    out  round finished with every play correct
//   errou      out  round finished on a wrong play or timeout
//   db_jogada  out  one-cycle key-press pulse (combinational, debug)
//   db_timeout out  round finished by timeout
//   db_estado  out  state code [3:0]
//
// state       | meaning
// ------------+------------------------------------------
// INICIAL     | idle after reset, waiting for iniciar
// PREPARACAO  | clear address counter and key register
// ESPERA      | waiting for a new key press
// REGISTRA    | load the pressed keys into the key register
// COMPARACAO  | sample the comparator
// PROXIMO     | advance to the next address
// FIM_ACERTOU | round won
// FIM_ERROU   | round lost on a wrong play
// FIM_TIMEOUT | round lost, no press in time

module unidade_controle_jogo #(
   parameter int TIMEOUT_CICLOS = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] chaves,
   input  logic       igual,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       db_jogada,
   output logic       db_timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARACAO  = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h4,
      COMPARACAO  = 4'h5,
      PROXIMO     = 4'h6,
      FIM_ACERTOU = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERROU   = 4'hE
   } estado_t;

   estado_t estado, proximo;
   logic    ativo, prev, jogada;
   logic    expirou;

   assign ativo  = |chaves;
   assign jogada = ativo & ~prev;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= INICIAL;
         prev   <= 1'b0;
      end else begin
         estado <= proximo;
         prev   <= ativo;
      end
   end

`ifdef TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (estado == ESPERA && proximo == ESPERA)
         cnt <= cnt + 1'b1;
      else
         cnt <= '0;
   end

   assign expirou = (cnt == CW'(TIMEOUT_CICLOS - 1));
`else
   assign expirou = 1'b0;
`endif

   always_comb begin
      proximo = INICIAL;
      case (estado)
         INICIAL:    proximo = iniciar ? PREPARACAO : INICIAL;
         PREPARACAO: proximo = ESPERA;
         // A press in the same cycle as the timeout takes priority.
         ESPERA: begin
            if (jogada)       proximo = REGISTRA;
            else if (expirou) proximo = FIM_TIMEOUT;
            else              proximo = ESPERA;
         end
         REGISTRA:   proximo = COMPARACAO;
         COMPARACAO: begin
            if (!igual)     proximo = FIM_ERROU;
            else if (fimC)  proximo = FIM_ACERTOU;
            else            proximo = PROXIMO;
         end
         PROXIMO:    proximo = ESPERA;
         FIM_ACERTOU,
         FIM_ERROU,
         FIM_TIMEOUT: proximo = iniciar ? PREPARACAO : estado;
         default:    proximo = INICIAL;
      endcase
   end

   always_comb begin
      zeraC      = 1'b0;
      contaC     = 1'b0;
      zeraR      = 1'b0;
      registraR  = 1'b0;
      pronto     = 1'b0;
      acertou    = 1'b0;
      errou      = 1'b0;
      db_timeout = 1'b0;
      case (estado)
         PREPARACAO:  begin zeraC = 1'b1; zeraR = 1'b1; end
         REGISTRA:    registraR = 1'b1;
         PROXIMO:     contaC = 1'b1;
         FIM_ACERTOU: begin pronto = 1'b1; acertou = 1'b1; end
         FIM_ERROU:   begin pronto = 1'b1; errou = 1'b1; end
`ifdef TIMEOUT_EN
         FIM_TIMEOUT: begin pronto = 1'b1; errou = 1'b1; db_timeout = 1'b1; end
`endif
         default: ;
      endcase
   end

   assign db_jogada = jogada;
   assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo. A small datapath model (address counter,
// 4-word ROM, key register, comparator) drives igual/fimC. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_unidade_controle_jogo;

   logic       clock = 1'b0;
   logic       reset, iniciar, igual, fimC;
   logic [3:0] chaves;
   logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou;
   logic       db_jogada, db_timeout;
   logic [3:0] db_estado;
   logic [7:0] outs;

   int n_vec = 0, n_err = 0;
   int n_reg = 0, n_cnt = 0, n_jog = 0;

   logic [1:0] addr;
   logic [3:0] key_reg;

   unidade_controle_jogo #(.TIMEOUT_CICLOS(8)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
      .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC),
      .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
      .acertou(acertou), .errou(errou), .db_jogada(db_jogada),
      .db_timeout(db_timeout), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   assign outs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_timeout};

   function automatic logic [3:0] rom(input logic [1:0] a);
      case (a)
         2'd0:    rom = 4'b0001;
         2'd1:    rom = 4'b0010;
         2'd2:    rom = 4'b1000;
         default: rom = 4'b0100;
      endcase
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr    <= 2'd0;
         key_reg <= 4'd0;
      end else begin
         if (zeraC)       addr <= 2'd0;
         else if (contaC) addr <= addr + 2'd1;
         if (zeraR)          key_reg <= 4'd0;
         else if (registraR) key_reg <= chaves;
      end
   end

   assign igual = (key_reg == rom(addr));
   assign fimC  = (addr == 2'd3);

   always @(posedge clock) begin
      if (reset) begin
         if (registraR) n_reg++;
         if (contaC)    n_cnt++;
         if (db_jogada) n_jog++;
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clock);
   endtask

   // One play: press k in ESPERA, release after REGISTRA, expect state fin after COMPARACAO.
   task automatic jogar(input logic [3:0] k, input logic [3:0] fin);
      chaves = k;
      #1 chk("jogada_pulse", {7'd0, db_jogada}, 8'd1);
      tick; chk("st_registra", {4'd0, db_estado}, 8'h04);
      chk("registraR", outs, 8'b0001_0000);
      tick; chk("st_comparacao", {4'd0, db_estado}, 8'h05);
      chaves = 4'd0;
      tick; chk("st_after_cmp", {4'd0, db_estado}, {4'd0, fin});
      if (fin == 4'h6) begin
         chk("contaC", outs, 8'b0100_0000);
         tick; chk("st_espera", {4'd0, db_estado}, 8'h02);
      end
   endtask

   initial begin
      reset = 1'b0; iniciar = 1'b0; chaves = 4'd0;
      #12;
      chk("rst_state", {4'd0, db_estado}, 8'h00);
      chk("rst_outs", outs, 8'h00);
      tick; reset = 1'b1;
      repeat (5) tick;
      chk("idle_state", {4'd0, db_estado}, 8'h00);
      chk("idle_outs", outs, 8'h00);

      // start
      iniciar = 1'b1;
      tick; chk("st_prep", {4'd0, db_estado}, 8'h01);
      chk("prep_outs", outs, 8'b1010_0000);
      iniciar = 1'b0;
      tick; chk("st_espera0", {4'd0, db_estado}, 8'h02);
      chk("espera_outs", outs, 8'h00);

      // correct round
      n_reg = 0; n_cnt = 0;
      jogar(4'b0001, 4'h6);
      jogar(4'b0010, 4'h6);
      jogar(4'b1000, 4'h6);
      jogar(4'b0100, 4'hA);
      chk("n_registraR", 8'(n_reg), 8'd4);
      chk("n_contaC", 8'(n_cnt), 8'd3);
      chk("acertou_outs", outs, 8'b0000_1100);

      // restart, wrong play at address 2
      iniciar = 1'b1;
      tick; chk("restart_prep", {4'd0, db_estado}, 8'h01);
      iniciar = 1'b0;
      tick;
      jogar(4'b0001, 4'h6);
      jogar(4'b0010, 4'h6);
      n_jog = 0;
      chaves = 4'b0100;
      tick; chk("wr_registra", {4'd0, db_estado}, 8'h04);
      tick; chk("wr_comparacao", {4'd0, db_estado}, 8'h05);
      tick; chk("st_errou", {4'd0, db_estado}, 8'h0E);
      chk("errou_outs", outs, 8'b0000_1010);
      chk("held_one_pulse", 8'(n_jog), 8'd1);
      chaves = 4'b0010;
      tick; chk("nz_to_nz_nopulse", 8'(n_jog), 8'd1);
      chaves = 4'd0;
      tick; chaves = 4'b0001;
      tick; chk("fim_ignores_press", {4'd0, db_estado}, 8'h0E);
      chaves = 4'd0;

      // restart from FIM_ERROU; iniciar held is ignored outside INICIAL/FIM
      iniciar = 1'b1;
      tick; chk("errou_restart", {4'd0, db_estado}, 8'h01);
      chk("errou_restart_outs", outs, 8'b1010_0000);
      tick; tick;
      chk("espera_ign_iniciar", {4'd0, db_estado}, 8'h02);
      iniciar = 1'b0;

      // asynchronous reset in REGISTRA
      chaves = 4'b0001;
      tick; chk("pre_rst_registra", {4'd0, db_estado}, 8'h04);
      #2 reset = 1'b0;
      #1 chk("async_rst_state", {4'd0, db_estado}, 8'h00);
      chk("async_rst_outs", outs, 8'h00);
      chaves = 4'd0;
      tick; reset = 1'b1;
      tick; chk("post_rst_idle", {4'd0, db_estado}, 8'h00);

      // timeout: 8 cycles in ESPERA
      iniciar = 1'b1; tick; iniciar = 1'b0; tick;
      chk("to_espera", {4'd0, db_estado}, 8'h02);
      repeat (7) tick;
      chk("to_still_espera", {4'd0, db_estado}, 8'h02);
      tick;
`ifdef TIMEOUT_EN
      chk("st_timeout", {4'd0, db_estado}, 8'h0D);
      chk("timeout_outs", outs, 8'b0000_1011);
`else
      chk("no_timeout_state", {4'd0, db_estado}, 8'h02);
      chk("no_timeout_flag", {7'd0, db_timeout}, 8'd0);
`endif

      // press on the 8th cycle wins over the timeout
      reset = 1'b0; tick; reset = 1'b1;
      iniciar = 1'b1; tick; iniciar = 1'b0; tick;
      repeat (7) tick;
      chaves = 4'b0001;
      tick; chk("press_beats_timeout", {4'd0, db_estado}, 8'h04);
      chaves = 4'd0;
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
